tlp_egress_drain: RTL and testbench

//   Downstream consumer of the transaction layer's four output FIFOs (data_out0..3).

---
 rtl/tlp_egress_drain.sv | 120 ++++++++++++
 tb/tb_tlp_egress_drain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_egress_drain.sv
// Egress drain for the four transaction-layer output FIFOs: round-robin pops into a
// 2-entry skid buffer presented as one valid/ready stream tagged with its source channel.
module tlp_egress_drain #(
   parameter int DATA_W = 10,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              empty0,
   input  logic              empty1,
   input  logic              empty2,
   input  logic              empty3,
   input  logic [DATA_W-1:0] data_out0,
   input  logic [DATA_W-1:0] data_out1,
   input  logic [DATA_W-1:0] data_out2,
   input  logic [DATA_W-1:0] data_out3,
   output logic              pop_out0,
   output logic              pop_out1,
   output logic              pop_out2,
   output logic              pop_out3,
   output logic [DATA_W-1:0] data_tx,
   output logic [1:0]        src_tx,
   output logic              valid_tx,
   input  logic              ready_tx,
   output logic [CNT_W-1:0]  tx_count
);

   typedef struct packed {
      logic [1:0]        src;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic [1:0]        last_q;
   logic              inflight_q;
   logic [1:0]        inflight_src_q;
   logic [1:0]        occ_q;
   entry_t            head_q, tail_q;

   logic [3:0]        empty_vec;
   logic [DATA_W-1:0] data_vec [4];
   logic              xfer, space, grant_vld, pop_fire;
   logic [1:0]        grant_ch, wr_slot, occ_n;
   logic [3:0]        pop_vec;
   entry_t            wr_entry, head_n, tail_n;

   assign empty_vec   = {empty3, empty2, empty1, empty0};
   assign data_vec[0] = data_out0;
   assign data_vec[1] = data_out1;
   assign data_vec[2] = data_out2;
   assign data_vec[3] = data_out3;

   assign valid_tx = (occ_q != 2'd0);
   assign data_tx  = head_q.data;
   assign src_tx   = head_q.src;
   assign xfer     = valid_tx & ready_tx;
   // Credit check: a pop is only issued if its word is guaranteed a buffer slot.
   assign space    = ({1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, xfer}) < 3'd2;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = last_q;
      for (int i = 1; i <= 4; i++) begin
         if (!grant_vld && !empty_vec[last_q + 2'(i)]) begin
            grant_vld = 1'b1;
            grant_ch  = last_q + 2'(i);
         end
      end
   end

   // Pops are gated by reset so an asserted reset silences the FIFOs in the same cycle.
   assign pop_fire = reset & enable & space & grant_vld;
   assign pop_vec  = pop_fire ? (4'b0001 << grant_ch) : 4'b0000;
   assign pop_out0 = pop_vec[0];
   assign pop_out1 = pop_vec[1];
   assign pop_out2 = pop_vec[2];
   assign pop_out3 = pop_vec[3];

   always_comb begin
      wr_entry = '{src: inflight_src_q, data: data_vec[inflight_src_q]};
      head_n   = head_q;
      tail_n   = tail_q;
      wr_slot  = occ_q - 2'(xfer);
      occ_n    = occ_q + 2'(inflight_q) - 2'(xfer);
      if (xfer && occ_q == 2'd2) head_n = tail_q;
      if (inflight_q) begin
         if (wr_slot == 2'd0) head_n = wr_entry;
         else                 tail_n = wr_entry;
      end
   end

   // NOTE: state registers use non-blocking assignments; the two buffer slots are
   // reset too because data_tx/src_tx must read 0 out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q         <= 2'd3;
         inflight_q     <= 1'b0;
         inflight_src_q <= 2'd0;
         occ_q          <= 2'd0;
         head_q         <= '0;
         tail_q         <= '0;
         tx_count       <= '0;
      end else begin
         inflight_q <= pop_fire;
         if (pop_fire) begin
            last_q         <= grant_ch;
            inflight_src_q <= grant_ch;
         end
         occ_q  <= occ_n;
         head_q <= head_n;
         tail_q <= tail_n;
         if (xfer) tx_count <= tx_count + CNT_W'(1);
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
      !(inflight_q && occ_q == 2'd2 && !xfer));

endmodule

// File: tb/tb_tlp_egress_drain.sv
// Directed bench for tlp_egress_drain: FIFO models feed the DUT, a per-channel
// scoreboard queue holds expected words, accepted words are popped and compared.
module tb_tlp_egress_drain;
   localparam int DATA_W = 10;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              reset, enable, ready_tx;
   logic              empty0, empty1, empty2, empty3;
   logic [DATA_W-1:0] data_out0, data_out1, data_out2, data_out3;
   logic              pop_out0, pop_out1, pop_out2, pop_out3;
   logic [DATA_W-1:0] data_tx;
   logic [1:0]        src_tx;
   logic              valid_tx;
   logic [CNT_W-1:0]  tx_count;

   int n_run = 0, n_fail = 0;

   always #5 clk = ~clk;

   tlp_egress_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
      .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
      .pop_out0(pop_out0), .pop_out1(pop_out1), .pop_out2(pop_out2), .pop_out3(pop_out3),
      .data_tx(data_tx), .src_tx(src_tx), .valid_tx(valid_tx), .ready_tx(ready_tx),
      .tx_count(tx_count)
   );

   // FIFO models: main process writes storage and push counts, the model owns pop counts.
   logic [DATA_W-1:0] mem [4][512];
   int                push_cnt [4];
   int                pop_cnt  [4];
   logic [DATA_W-1:0] dq [4];
   logic [3:0]        pop_s = 4'b0000;
   logic              pop_err = 1'b0;

   assign empty0 = (push_cnt[0] == pop_cnt[0]);
   assign empty1 = (push_cnt[1] == pop_cnt[1]);
   assign empty2 = (push_cnt[2] == pop_cnt[2]);
   assign empty3 = (push_cnt[3] == pop_cnt[3]);
   assign data_out0 = dq[0];
   assign data_out1 = dq[1];
   assign data_out2 = dq[2];
   assign data_out3 = dq[3];

   always @(posedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (pop_s[c]) begin
            if (push_cnt[c] == pop_cnt[c]) pop_err <= 1'b1;
            dq[c]      <= mem[c][pop_cnt[c] % 512];
            pop_cnt[c] <= pop_cnt[c] + 1;
         end
      end
   end

   // Scoreboard and logs, all owned by the main process.
   logic [DATA_W-1:0] exp_q [4][$];
   int pop_log[$];
   int src_log[$];
   int acc_cyc[$];
   int n_acc = 0, model_cnt = 0, cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int c, input logic [DATA_W-1:0] d);
      mem[c][push_cnt[c] % 512] = d;
      push_cnt[c]++;
      exp_q[c].push_back(d);
   endtask

   // One clock: sample pops and transfers on the falling edge, return 1 after the rising edge.
   task automatic cycle();
      logic [DATA_W-1:0] e;
      @(negedge clk);
      pop_s = {pop_out3, pop_out2, pop_out1, pop_out0};
      check("pop_onehot0", 32'($onehot0(pop_s)), 1);
      for (int c = 0; c < 4; c++) if (pop_s[c]) pop_log.push_back(c);
      if (reset && valid_tx && ready_tx) begin
         check("sb_has_entry", 32'(exp_q[src_tx].size() != 0), 1);
         if (exp_q[src_tx].size() != 0) begin
            e = exp_q[src_tx].pop_front();
            check("sb_data", 32'(data_tx), 32'(e));
         end
         src_log.push_back(int'(src_tx));
         acc_cyc.push_back(cyc);
         n_acc++;
         model_cnt++;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int target, input int budget, input string tag);
      int k = 0;
      while (n_acc < target && k < budget) begin
         cycle();
         k++;
      end
      check(tag, 32'(n_acc >= target), 1);
   endtask

   task automatic clear_logs();
      pop_log.delete();
      src_log.delete();
      acc_cyc.delete();
   endtask

   initial begin
      int base, p0, acc_before;
      logic [DATA_W-1:0] hd;

      reset = 1'b0; enable = 1'b0; ready_tx = 1'b0;
      #1;
      check("rst_valid", 32'(valid_tx), 0);
      check("rst_data", 32'(data_tx), 0);
      check("rst_src", 32'(src_tx), 0);
      check("rst_count", 32'(tx_count), 0);
      repeat (3) cycle();
      reset = 1'b1; enable = 1'b1; ready_tx = 1'b1;
      cycle();

      // Round robin across four loaded FIFOs, one word per cycle.
      clear_logs();
      base = n_acc;
      for (int i = 0; i < 3; i++)
         for (int c = 0; c < 4; c++) push(c, 10'(c * 16 + i + 1));
      wait_acc(base + 12, 60, "rr_timeout");
      check("rr_pop_n", 32'(pop_log.size()), 12);
      check("rr_acc_n", 32'(src_log.size()), 12);
      if (pop_log.size() == 12 && src_log.size() == 12) begin
         for (int k = 0; k < 12; k++) begin
            check("rr_pop_order", 32'(pop_log[k]), 32'(k % 4));
            check("rr_src_order", 32'(src_log[k]), 32'(k % 4));
            if (k > 0) check("rr_b2b", 32'(acc_cyc[k]), 32'(acc_cyc[k-1] + 1));
         end
      end
      check("rr_count", 32'(tx_count), 12);

      // Single word from FIFO2: latency and counter.
      push(2, 10'h2A5);
      #1;
      check("lat_pop", 32'({pop_out3, pop_out2, pop_out1, pop_out0}), 32'h4);
      cycle();
      check("lat_n1_valid", 32'(valid_tx), 0);
      cycle();
      check("lat_n2_valid", 32'(valid_tx), 1);
      check("lat_n2_data", 32'(data_tx), 32'h2A5);
      check("lat_n2_src", 32'(src_tx), 2);
      cycle();
      check("lat_count", 32'(tx_count), 13);

      // Backpressure: credit limits pops to two, head stays stable.
      ready_tx = 1'b0;
      clear_logs();
      base = n_acc;
      for (int i = 0; i < 5; i++) push(0, 10'h100 + 10'(i));
      repeat (10) cycle();
      check("bp_pops", 32'(pop_log.size()), 2);
      check("bp_valid", 32'(valid_tx), 1);
      check("bp_head", 32'(data_tx), 32'h100);
      hd = data_tx;
      repeat (3) cycle();
      check("bp_stable", 32'(data_tx), 32'(hd));
      check("bp_pops_hold", 32'(pop_log.size()), 2);
      ready_tx = 1'b1;
      wait_acc(base + 5, 40, "bp_timeout");
      check("bp_pops_total", 32'(pop_log.size()), 5);
      check("bp_sb_empty", 32'(exp_q[0].size()), 0);
      check("bp_count", 32'(tx_count), 18);

      // Enable drop during a FIFO1 stream; resume searches from channel 2.
      clear_logs();
      base = n_acc;
      for (int i = 0; i < 10; i++) push(1, 10'h200 + 10'(i));
      repeat (4) cycle();
      enable = 1'b0;
      push(0, 10'h0F0);
      push(2, 10'h2F0);
      p0 = pop_log.size();
      acc_before = n_acc;
      repeat (4) cycle();
      check("en_no_pop", 32'(pop_log.size()), 32'(p0));
      check("en_drain", 32'(n_acc > acc_before), 1);
      enable = 1'b1;
      repeat (3) cycle();
      check("en_resume_n", 32'(pop_log.size() >= p0 + 3), 1);
      if (pop_log.size() >= p0 + 3) begin
         check("en_resume0", 32'(pop_log[p0]), 2);
         check("en_resume1", 32'(pop_log[p0+1]), 0);
         check("en_resume2", 32'(pop_log[p0+2]), 1);
      end
      wait_acc(base + 12, 60, "en_timeout");

      // Reset mid-stream with the buffer full.
      ready_tx = 1'b0;
      clear_logs();
      for (int i = 0; i < 3; i++) push(0, 10'h300 + 10'(i));
      repeat (6) cycle();
      check("mrst_pre_valid", 32'(valid_tx), 1);
      check("mrst_pre_pops", 32'(pop_log.size()), 2);
      reset = 1'b0;
      #1;
      check("mrst_pops", 32'({pop_out3, pop_out2, pop_out1, pop_out0}), 0);
      check("mrst_valid", 32'(valid_tx), 0);
      check("mrst_count", 32'(tx_count), 0);
      for (int c = 0; c < 4; c++) begin
         push_cnt[c] = pop_cnt[c];
         exp_q[c].delete();
      end
      model_cnt = 0;
      repeat (2) cycle();
      reset = 1'b1;
      ready_tx = 1'b1;
      clear_logs();
      base = n_acc;
      push(0, 10'h3AA);
      cycle();
      check("mrst_first_n", 32'(pop_log.size()), 1);
      if (pop_log.size() == 1) check("mrst_first_ch", 32'(pop_log[0]), 0);
      wait_acc(base + 1, 20, "mrst_timeout");
      check("mrst_count1", 32'(tx_count), 1);

      // 256 more words (257 since reset) with random backpressure: counter wraps to 1.
      base = n_acc;
      for (int i = 0; i < 256; i++) push(int'($urandom_range(0, 3)), 10'($urandom));
      begin
         int k = 0;
         while (n_acc < base + 256 && k < 3000) begin
            cycle();
            ready_tx = 1'($urandom_range(0, 1));
            k++;
         end
      end
      ready_tx = 1'b1;
      check("wrap_done", 32'(n_acc - base), 256);
      cycle();
      check("wrap_count", 32'(tx_count), 1);
      check("wrap_model", 32'(tx_count), 32'(model_cnt % 256));
      for (int c = 0; c < 4; c++) check("wrap_sb_empty", 32'(exp_q[c].size()), 0);
      check("no_pop_on_empty", 32'(pop_err), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
